// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter feeding the 7-segment scan driver.
// FSM encoding, legal width range and the largest value three BCD digits can show.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int BCD_MAX   = 999;
    localparam int WIDTH_MIN = 4;
    localparam int WIDTH_MAX = 10;

    // Nibbles at or above this value would exceed 9 after the next doubling.
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
// Inputs 5..9 map to 8..12, so the 4-bit add never carries out.
module bin_to_bcd_seq_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [3:0] adjusted
);

    assign adjusted = (nibble >= ADD3_THRESHOLD) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Digits are only updated on completion so the display never shows intermediate values.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] bin,
    output logic [3:0]       ones,
    output logic [3:0]       tens,
    output logic [3:0]       hundreds,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int SW = WIDTH + 12;

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
        $fatal(1, "bin_to_bcd_seq: WIDTH must lie in 4..10");
    end

    state_t          state_reg, state_next;
    logic [SW-1:0]   scratch_reg, scratch_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic            ovf_reg, ovf_next;
    logic [3:0]      ones_reg, tens_reg, hundreds_reg;
    logic            done_reg, overflow_reg;
    logic [11:0]     bcd_adj;
    logic [SW-1:0]   scratch_adj;

    // Scratch layout: {hundreds, tens, ones, remaining binary bits}.
    for (genvar gi = 0; gi < 3; gi++) begin : g_add3
        bin_to_bcd_seq_add3 u_add3 (
            .nibble   (scratch_reg[WIDTH + 4*gi +: 4]),
            .adjusted (bcd_adj[4*gi +: 4])
        );
    end

    assign scratch_adj = {bcd_adj, scratch_reg[WIDTH-1:0]};

    always_comb begin
        state_next   = state_reg;
        scratch_next = scratch_reg;
        cnt_next     = cnt_reg;
        ovf_next     = ovf_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next   = ST_SHIFT;
                    scratch_next = {12'd0, bin};
                    cnt_next     = CW'(WIDTH);
                    ovf_next     = 32'(bin) > 32'(BCD_MAX);
                end
            end
            ST_SHIFT: begin
                scratch_next = {scratch_adj[SW-2:0], 1'b0};
                cnt_next     = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            scratch_reg  <= '0;
            cnt_reg      <= '0;
            ovf_reg      <= 1'b0;
            ones_reg     <= 4'd0;
            tens_reg     <= 4'd0;
            hundreds_reg <= 4'd0;
            done_reg     <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            scratch_reg <= scratch_next;
            cnt_reg     <= cnt_next;
            ovf_reg     <= ovf_next;
            done_reg    <= (state_reg == ST_DONE);
            if (state_reg == ST_DONE) begin
                overflow_reg <= ovf_reg;
                // Out-of-range values saturate rather than show truncated digits.
                if (ovf_reg) begin
                    ones_reg     <= 4'd9;
                    tens_reg     <= 4'd9;
                    hundreds_reg <= 4'd9;
                end else begin
                    ones_reg     <= scratch_reg[WIDTH +: 4];
                    tens_reg     <= scratch_reg[WIDTH + 4 +: 4];
                    hundreds_reg <= scratch_reg[WIDTH + 8 +: 4];
                end
            end
        end
    end

    assign ones     = ones_reg;
    assign tens     = tens_reg;
    assign hundreds = hundreds_reg;
    assign busy     = (state_reg != ST_IDLE);
    assign done     = done_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: one WIDTH=8 and one WIDTH=10 instance checked
// against an arithmetic decimal-digit model.
module tb_bin_to_bcd_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start8 = 1'b0;
    logic [7:0] bin8 = '0;
    logic [3:0] ones8, tens8, hund8;
    logic       busy8, done8, ovf8;
    logic       start10 = 1'b0;
    logic [9:0] bin10 = '0;
    logic [3:0] ones10, tens10, hund10;
    logic       busy10, done10, ovf10;

    logic       sel = 1'b0;
    logic [3:0] o_ones, o_tens, o_hund;
    logic       o_busy, o_done, o_ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .bin(bin8),
        .ones(ones8), .tens(tens8), .hundreds(hund8),
        .busy(busy8), .done(done8), .overflow(ovf8)
    );

    bin_to_bcd_seq #(.WIDTH(10)) dut10 (
        .clk(clk), .reset(reset), .start(start10), .bin(bin10),
        .ones(ones10), .tens(tens10), .hundreds(hund10),
        .busy(busy10), .done(done10), .overflow(ovf10)
    );

    always_comb begin
        o_ones = sel ? ones10 : ones8;
        o_tens = sel ? tens10 : tens8;
        o_hund = sel ? hund10 : hund8;
        o_busy = sel ? busy10 : busy8;
        o_done = sel ? done10 : done8;
        o_ovf  = sel ? ovf10  : ovf8;
    end

    // {overflow, hundreds, tens, ones} expected for a value, by plain decimal arithmetic.
    function automatic logic [12:0] ref_bcd(input int v);
        if (v > 999) return {1'b1, 12'h999};
        return {1'b0, 4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Pulse start for one cycle on the selected instance and wait (bounded) for done.
    task automatic convert(input bit w10, input int v, output int lat, output int bcnt, output bit ok);
        sel = w10;
        @(negedge clk);
        if (w10) begin bin10 = v[9:0]; start10 = 1'b1; end
        else begin bin8 = v[7:0]; start8 = 1'b1; end
        lat = 0; bcnt = 0; ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start8 = 1'b0; start10 = 1'b0;
            lat++;
            if (o_busy) bcnt++;
            if (o_done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({ovf8, hund8, tens8, ones8, busy8, done8} !== 15'd0) begin
            bad++; $display("FAIL reset_w8 got=%h exp=0", {ovf8, hund8, tens8, ones8, busy8, done8});
        end
        total++;
        if ({ovf10, hund10, tens10, ones10, busy10, done10} !== 15'd0) begin
            bad++; $display("FAIL reset_w10 got=%h exp=0", {ovf10, hund10, tens10, ones10, busy10, done10});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero;
        int lat, bcnt; bit ok;
        convert(1'b0, 0, lat, bcnt, ok);
        total++;
        if (!ok || lat !== 10) begin bad++; $display("FAIL zero_latency got=%0d exp=10 ok=%0d", lat, ok); end
        total++;
        if ({o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(0)) begin
            bad++; $display("FAIL zero_digits got=%h exp=%h", {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(0));
        end
        $display("conv w8 bin=0 -> %0d%0d%0d ovf=%0d lat=%0d", o_hund, o_tens, o_ones, o_ovf, lat);
    endtask

    task automatic test_max8;
        int lat, bcnt; bit ok;
        convert(1'b0, 255, lat, bcnt, ok);
        total++;
        if (!ok || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(255)) begin
            bad++; $display("FAIL max8_digits got=%h exp=%h ok=%0d", {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(255), ok);
        end
        total++;
        if (bcnt !== 9) begin bad++; $display("FAIL max8_busy_cycles got=%0d exp=9", bcnt); end
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++; $display("FAIL max8_done_width got done=%0d busy=%0d exp 0 0", o_done, o_busy);
        end
        $display("conv w8 bin=255 -> %0d%0d%0d busy=%0d", o_hund, o_tens, o_ones, bcnt);
    endtask

    task automatic test_start_ignored;
        int lat, bcnt, extra; bit ok;
        sel = 1'b0;
        @(negedge clk);
        bin8 = 8'd128; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);
        bin8 = 8'd77; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (o_done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        total++;
        if (!ok || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(128)) begin
            bad++; $display("FAIL restart_ignored got=%h exp=%h ok=%0d", {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(128), ok);
        end
        extra = 0;
        repeat (15) begin @(negedge clk); if (o_done) extra++; end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL restart_single_done got=%0d extra exp=0", extra); end
        convert(1'b0, 77, lat, bcnt, ok);
        total++;
        if (!ok || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(77)) begin
            bad++; $display("FAIL fresh77 got=%h exp=%h ok=%0d", {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(77), ok);
        end
        $display("conv w8 bin=128 with restart attempt, then bin=77 -> %0d%0d%0d", o_hund, o_tens, o_ones);
    endtask

    task automatic test_reset_mid;
        int lat, bcnt, extra; bit ok;
        sel = 1'b0;
        @(negedge clk);
        bin8 = 8'd255; start8 = 1'b1;
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        total++;
        if ({o_busy, o_done, o_ovf, o_hund, o_tens, o_ones} !== 15'd0) begin
            bad++; $display("FAIL reset_mid got=%h exp=0", {o_busy, o_done, o_ovf, o_hund, o_tens, o_ones});
        end
        extra = 0;
        repeat (15) begin @(negedge clk); if (o_done) extra++; end
        total++;
        if (extra !== 0) begin bad++; $display("FAIL reset_mid_no_done got=%0d exp=0", extra); end
        convert(1'b0, 9, lat, bcnt, ok);
        total++;
        if (!ok || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(9)) begin
            bad++; $display("FAIL after_reset9 got=%h exp=%h ok=%0d", {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(9), ok);
        end
        $display("reset mid-conversion, then bin=9 -> %0d%0d%0d", o_hund, o_tens, o_ones);
    endtask

    task automatic test_width10;
        int vals[$] = '{999, 1000, 1023, 0, 512};
        int lat, bcnt; bit ok;
        for (int i = 0; i < 6; i++) vals.push_back($urandom_range(1023));
        foreach (vals[i]) begin
            convert(1'b1, vals[i], lat, bcnt, ok);
            total++;
            if (!ok || lat !== 12 || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(vals[i])) begin
                bad++; $display("FAIL w10_bin%0d got=%h exp=%h lat=%0d exp_lat=12 ok=%0d",
                                vals[i], {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(vals[i]), lat, ok);
            end
            $display("conv w10 bin=%0d -> %0d%0d%0d ovf=%0d", vals[i], o_hund, o_tens, o_ones, o_ovf);
        end
    endtask

    task automatic test_random8;
        int v, lat, bcnt; bit ok;
        for (int i = 0; i < 12; i++) begin
            v = $urandom_range(255);
            convert(1'b0, v, lat, bcnt, ok);
            total++;
            if (!ok || lat !== 10 || {o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(v)) begin
                bad++; $display("FAIL w8_rand%0d got=%h exp=%h lat=%0d ok=%0d",
                                v, {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(v), lat, ok);
            end
            $display("conv w8 bin=%0d -> %0d%0d%0d", v, o_hund, o_tens, o_ones);
        end
    endtask

    // start held high; bin is scrambled while busy and set to the next sweep value on each done.
    task automatic test_back_to_back;
        int k, cyc, last, nbad;
        sel = 1'b0; k = 0; cyc = 0; last = -1; nbad = 0;
        @(negedge clk);
        bin8 = 8'd0; start8 = 1'b1;
        while (k < 256 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (o_done) begin
                total++;
                if ({o_ovf, o_hund, o_tens, o_ones} !== ref_bcd(k) || (last >= 0 && cyc - last !== 10)) begin
                    bad++; nbad++;
                    $display("FAIL b2b_bin%0d got=%h exp=%h spacing=%0d exp_spacing=10",
                             k, {o_ovf, o_hund, o_tens, o_ones}, ref_bcd(k), cyc - last);
                end
                last = cyc;
                k++;
                bin8 = k[7:0];
            end else begin
                bin8 = 8'($urandom);
            end
        end
        start8 = 1'b0;
        total++;
        if (k !== 256) begin bad++; $display("FAIL b2b_timeout got=%0d conversions exp=256", k); end
        $display("back-to-back sweep 0..255: %0d conversions, %0d wrong", k, nbad);
        repeat (15) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_max8();
        test_start_ignored();
        test_reset_mid();
        test_width10();
        test_random8();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
